jtframe_dwnld_sched: RTL and testbench

Download scheduler between the HPS ioctl stream and the SDRAM programming port. It buffers ioctl writes in a small FIFO and splits 16-bit words into byte writes. Byte writes are issued on a req/ack handshake instead of a fixed delay, and the HPS is back-pressured through ioctl_wait. It also decodes the ioctl index: ROM data goes to SDRAM, while core_mod and MRA DIP bytes are captured locally.

---
 rtl/jtframe_dwnld_pkg.sv | 23 ++
 rtl/jtframe_dwnld_fifo.sv | 49 ++++
 rtl/jtframe_dwnld_sched.sv | 166 ++++++++++++++++
 tb/tb_jtframe_dwnld_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the download scheduler: sequencer states, FIFO entry layout
// and the default ioctl index assignments.
package jtframe_dwnld_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } dwnld_st_t;

   typedef struct packed {
      logic [24:0] addr;
      logic [15:0] data;
      logic        two;
   } dwnld_entry_t;

   localparam int ENTRY_W = $bits(dwnld_entry_t);

   localparam logic [7:0] ROM_IDX_DEF = 8'd0;
   localparam logic [7:0] MOD_IDX_DEF = 8'd1;
   localparam logic [7:0] DIP_IDX_DEF = 8'd254;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is discarded; almost_full
// comes straight from the occupancy register so it carries no input path.
module jtframe_dwnld_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic         almost_full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full        = cnt == (AW+1)'(DEPTH);
   assign empty       = cnt == '0;
   assign almost_full = cnt >= (AW+1)'(DEPTH-1);
   assign do_push     = push && !full;
   assign do_pop      = pop && !empty;
   assign dout        = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtframe_dwnld_sched.sv
// Download scheduler: buffers ROM ioctl writes, issues them as byte writes on a
// prog_we/prog_ack handshake and captures core_mod and DIP bytes locally.
module jtframe_dwnld_sched
   import jtframe_dwnld_pkg::*;
#(
   parameter bit         WIDE    = 1'b0,
   parameter int         DEPTH   = 4,
   parameter logic [7:0] ROM_IDX = ROM_IDX_DEF,
   parameter logic [7:0] MOD_IDX = MOD_IDX_DEF,
   parameter logic [7:0] DIP_IDX = DIP_IDX_DEF
) (
   input  logic        clk_rom,
   input  logic        rst,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic        ioctl_wait,
   output logic [24:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic        prog_we,
   input  logic        prog_ack,
   output logic        downloading,
   output logic        dwnld_done,
   output logic        ovf,
   output logic [6:0]  core_mod,
   output logic [31:0] dipsw
);

   // Handshake: prog_addr/prog_data are valid while prog_we=1 and stay frozen
   // until the cycle prog_ack=1; that cycle consumes the byte.

   logic               is_rom, is_mod, is_dip;
   logic               fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_afull;
   logic [ENTRY_W-1:0] fifo_din, fifo_dout;
   dwnld_entry_t       head;

   dwnld_st_t          st, st_nxt;
   logic [24:0]        addr_nxt;
   logic [7:0]         data_nxt;
   logic               we_nxt;

   logic               rom_dl, rom_dl_l, drained;
   logic [1:0]         lane, lane_hi;

   assign is_rom    = ioctl_index == ROM_IDX;
   assign is_mod    = ioctl_index == MOD_IDX;
   assign is_dip    = ioctl_index == DIP_IDX;
   assign fifo_push = ioctl_wr && is_rom;
   assign fifo_din  = {ioctl_addr[24:0], ioctl_dout, WIDE};
   assign head      = fifo_dout;
   assign ioctl_wait = fifo_afull;

   jtframe_dwnld_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk         (clk_rom),
      .rst         (rst),
      .push        (fifo_push),
      .pop         (fifo_pop),
      .din         (fifo_din),
      .dout        (fifo_dout),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .almost_full (fifo_afull)
   );

   always_ff @(posedge clk_rom or posedge rst) begin
      if (rst) begin
         st        <= ST_IDLE;
         prog_addr <= '0;
         prog_data <= '0;
         prog_we   <= 1'b0;
      end else begin
         st        <= st_nxt;
         prog_addr <= addr_nxt;
         prog_data <= data_nxt;
         prog_we   <= we_nxt;
      end
   end

   // The head entry is only popped once its last byte is acknowledged
   always_comb begin
      st_nxt   = st;
      addr_nxt = prog_addr;
      data_nxt = prog_data;
      we_nxt   = prog_we;
      fifo_pop = 1'b0;
      case (st)
         ST_IDLE: begin
            if (!fifo_empty) begin
               addr_nxt = head.addr;
               data_nxt = head.data[7:0];
               we_nxt   = 1'b1;
               st_nxt   = ST_LO;
            end
         end
         ST_LO: begin
            if (prog_ack) begin
               if (head.two) begin
                  addr_nxt = head.addr | 25'd1;
                  data_nxt = head.data[15:8];
                  st_nxt   = ST_HI;
               end else begin
                  fifo_pop = 1'b1;
                  we_nxt   = 1'b0;
                  st_nxt   = ST_IDLE;
               end
            end
         end
         ST_HI: begin
            if (prog_ack) begin
               fifo_pop = 1'b1;
               we_nxt   = 1'b0;
               st_nxt   = ST_IDLE;
            end
         end
         default: begin
            we_nxt = 1'b0;
            st_nxt = ST_IDLE;
         end
      endcase
   end

   assign rom_dl  = ioctl_download && is_rom;
   assign drained = !ioctl_download && fifo_empty && st == ST_IDLE;

   always_ff @(posedge clk_rom or posedge rst) begin
      if (rst) begin
         rom_dl_l    <= 1'b0;
         downloading <= 1'b0;
         dwnld_done  <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         rom_dl_l   <= rom_dl;
         dwnld_done <= 1'b0;
         if (rom_dl && !rom_dl_l) begin
            downloading <= 1'b1;
         end else if (downloading && drained) begin
            downloading <= 1'b0;
            dwnld_done  <= 1'b1;
         end
         if (fifo_push && fifo_full) ovf <= 1'b1;
      end
   end

   assign lane    = ioctl_addr[1:0];
   assign lane_hi = lane + 2'd1;

   // addr[0] guard stops the second byte of a core_mod download clobbering the first
   always_ff @(posedge clk_rom or posedge rst) begin
      if (rst) begin
         core_mod <= 7'h7F;
         dipsw    <= '0;
      end else begin
         if (ioctl_wr && is_mod && !ioctl_addr[0]) core_mod <= ioctl_dout[6:0];
         if (ioctl_wr && is_dip && ioctl_addr[26:2] == '0) begin
            dipsw[{lane, 3'b000} +: 8] <= ioctl_dout[7:0];
            if (WIDE) dipsw[{lane_hi, 3'b000} +: 8] <= ioctl_dout[15:8];
         end
      end
   end

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Bench for jtframe_dwnld_sched: an 8-bit and a 16-bit instance share the ioctl
// stimulus; each has its own randomised prog_ack responder and byte scoreboard.
module tb_jtframe_dwnld_sched;

   localparam logic [7:0] ROM = 8'd0;
   localparam logic [7:0] MOD = 8'd1;
   localparam logic [7:0] DIP = 8'd254;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [26:0] ioctl_addr = '0;
   logic [15:0] ioctl_dout = '0;

   logic [1:0]  io_wait, prog_we, downloading, dwnld_done, ovf;
   logic [1:0]  prog_ack = 2'b00;
   logic [24:0] prog_addr [2];
   logic [7:0]  prog_data [2];
   logic [6:0]  core_mod [2];
   logic [31:0] dipsw [2];

   int          n_checks = 0;
   int          n_fail = 0;
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic        ack_en = 1'b1;
   int          ack_dly[2] = '{1, 2};
   int          done_cnt[2] = '{0, 0};
   logic [1:0]  wait_seen = 2'b00;
   logic        hold_pend = 1'b0;
   logic [24:0] hold_addr = '0;
   logic [6:0]  mod_m;
   logic [7:0]  dip_m [2][4];

   jtframe_dwnld_sched #(.WIDE(1'b0), .DEPTH(4)) u_dut8 (
      .clk_rom(clk), .rst(rst), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(io_wait[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]),
      .prog_we(prog_we[0]), .prog_ack(prog_ack[0]), .downloading(downloading[0]),
      .dwnld_done(dwnld_done[0]), .ovf(ovf[0]), .core_mod(core_mod[0]), .dipsw(dipsw[0])
   );

   jtframe_dwnld_sched #(.WIDE(1'b1), .DEPTH(4)) u_dut16 (
      .clk_rom(clk), .rst(rst), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(io_wait[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]),
      .prog_we(prog_we[1]), .prog_ack(prog_ack[1]), .downloading(downloading[1]),
      .dwnld_done(dwnld_done[1]), .ovf(ovf[1]), .core_mod(core_mod[1]), .dipsw(dipsw[1])
   );

   // clock / reset
   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // prog_ack responder: one-cycle ack after a random delay per request
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         prog_ack[d] = 1'b0;
         if (ack_en && prog_we[d] && !rst) begin
            if (ack_dly[d] == 0) begin
               prog_ack[d] = 1'b1;
               ack_dly[d] = $urandom_range(0, 2);
            end else begin
               ack_dly[d] = ack_dly[d] - 1;
            end
         end
      end
   end

   // monitor: every accepted byte is popped from that instance's queue
   always @(negedge clk) begin
      logic [32:0] got, exp;
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         wait_seen = wait_seen | io_wait;
         for (int d = 0; d < 2; d++) begin
            if (dwnld_done[d]) done_cnt[d] = done_cnt[d] + 1;
         end
         if (hold_pend) begin
            check("hi_follow", {38'd0, prog_we[1], prog_addr[1]}, {38'd0, 1'b1, hold_addr});
            hold_pend = 1'b0;
         end
         for (int d = 0; d < 2; d++) begin
            if (prog_we[d] && prog_ack[d]) begin
               got = {prog_addr[d], prog_data[d]};
               if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                  check(d == 0 ? "unexpected_byte8" : "unexpected_byte16", {31'd0, got}, 64'd0);
               end else begin
                  exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check(d == 0 ? "byte8" : "byte16", {31'd0, got}, {31'd0, exp});
               end
            end
         end
         if (prog_we[1] && prog_ack[1] && !prog_addr[1][0]) begin
            hold_pend = 1'b1;
            hold_addr = prog_addr[1] | 25'd1;
         end
      end
   end

   // driver tasks
   task automatic ioctl_write(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] dout);
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = dout;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
      if (idx == MOD && !addr[0]) mod_m = dout[6:0];
      if (idx == DIP && addr[26:2] == '0) begin
         dip_m[0][addr[1:0]] = dout[7:0];
         dip_m[1][addr[1:0]] = dout[7:0];
         dip_m[1][(addr[1:0] + 1) % 4] = dout[15:8];
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (io_wait != 2'b00 && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) check("wait_timeout", 64'd1, 64'd0);
   endtask

   task automatic rom_write(input logic [26:0] addr, input logic [15:0] data,
                            input bit respect_wait, input bit lands);
      if (respect_wait) wait_ready();
      ioctl_write(ROM, addr, data);
      if (lands) begin
         exp_q0.push_back({addr[24:0], data[7:0]});
         exp_q1.push_back({addr[24:0], data[7:0]});
         exp_q1.push_back({addr[24:0] | 25'd1, data[15:8]});
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || prog_we != 2'b00) && n < 4000) begin
         tick();
         n++;
      end
      if (n >= 4000) check("drain_timeout", {32'd0, exp_q0.size()}, 64'd0);
      repeat (3) tick();
   endtask

   // stimulus
   initial begin
      logic [26:0] a;
      logic [15:0] v;
      logic [31:0] dip_w;
      mod_m = 7'h7F;
      for (int i = 0; i < 4; i++) begin
         dip_m[0][i] = 8'h00;
         dip_m[1][i] = 8'h00;
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         check("rst_wait", {63'd0, io_wait[d]}, 64'd0);
         check("rst_prog_we", {63'd0, prog_we[d]}, 64'd0);
         check("rst_prog_addr", {39'd0, prog_addr[d]}, 64'd0);
         check("rst_prog_data", {56'd0, prog_data[d]}, 64'd0);
         check("rst_downloading", {63'd0, downloading[d]}, 64'd0);
         check("rst_done", {63'd0, dwnld_done[d]}, 64'd0);
         check("rst_ovf", {63'd0, ovf[d]}, 64'd0);
         check("rst_core_mod", {57'd0, core_mod[d]}, 64'h7F);
         check("rst_dipsw", {32'd0, dipsw[d]}, 64'd0);
      end
      rst = 1'b0;
      tick();

      // three spaced byte writes
      ioctl_index = ROM;
      ioctl_download = 1'b1;
      repeat (2) tick();
      check("dl_start", {62'd0, downloading}, 64'd3);
      for (int i = 0; i < 3; i++) begin
         rom_write(27'(i), {8'($urandom), 8'hA0 + 8'(i)}, 1'b1, 1'b1);
         repeat (6) tick();
      end
      ioctl_download = 1'b0;
      drain();
      check("wait_quiet8", {63'd0, wait_seen[0]}, 64'd0);
      check("done8_once", {32'd0, done_cnt[0]}, 64'd1);
      check("done16_once", {32'd0, done_cnt[1]}, 64'd1);
      check("dl_end", {62'd0, downloading}, 64'd0);

      // one 16-bit word
      ioctl_download = 1'b1;
      tick();
      rom_write(27'h10, 16'hBEEF, 1'b1, 1'b1);
      ioctl_download = 1'b0;
      drain();
      check("done16_word", {32'd0, done_cnt[1]}, 64'd2);

      // randomised burst honouring ioctl_wait
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) begin
         a = 27'($urandom) & ~27'd1;
         v = 16'($urandom);
         rom_write(a, v, 1'b1, 1'b1);
         repeat ($urandom_range(0, 3)) tick();
      end
      ioctl_download = 1'b0;
      drain();
      check("done_random", {32'd0, done_cnt[0]}, 64'd3);
      check("no_ovf", {62'd0, ovf}, 64'd0);

      // overflow with ack withheld
      ioctl_download = 1'b1;
      ack_en = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         rom_write(27'h100 + 27'(2 * i), 16'($urandom), 1'b0, i < 4);
         if (i == 1) check("wait_after2", {62'd0, io_wait}, 64'd0);
         if (i == 2) check("wait_after3", {62'd0, io_wait}, 64'd3);
         if (i == 4) check("ovf_set", {62'd0, ovf}, 64'd3);
      end
      ack_en = 1'b1;
      ioctl_download = 1'b0;
      drain();
      check("ovf_sticky", {62'd0, ovf}, 64'd3);
      check("done_ovf", {32'd0, done_cnt[1]}, 64'd4);

      // core_mod and DIP capture
      ioctl_write(MOD, 27'd0, 16'h0005);
      ioctl_write(MOD, 27'd1, 16'h007F);
      tick();
      check("core_mod8", {57'd0, core_mod[0]}, 64'h05);
      check("core_mod16", {57'd0, core_mod[1]}, {57'd0, mod_m});
      for (int i = 0; i < 4; i++) ioctl_write(DIP, 27'(i), {8'($urandom), 8'h11 * 8'(i + 1)});
      ioctl_write(DIP, 27'd4, {8'($urandom), 8'h55});
      tick();
      check("dipsw8", {32'd0, dipsw[0]}, 64'h44332211);
      dip_w = {dip_m[1][3], dip_m[1][2], dip_m[1][1], dip_m[1][0]};
      check("dipsw16", {32'd0, dipsw[1]}, {32'd0, dip_w});
      check("no_prog_side", {62'd0, prog_we}, 64'd0);

      // reset while the wide instance is on its high byte
      ioctl_index = ROM;
      ioctl_download = 1'b1;
      tick();
      rom_write(27'h20, 16'($urandom), 1'b1, 1'b1);
      begin
         int n = 0;
         @(negedge clk);
         while (!(prog_we[1] && prog_addr[1][0]) && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) check("hi_timeout", 64'd1, 64'd0);
      end
      #1;
      rst = 1'b1;
      ioctl_download = 1'b0;
      #1;
      check("rst_hi_we", {62'd0, prog_we}, 64'd0);
      check("rst_hi_dl", {62'd0, downloading}, 64'd0);
      check("rst_hi_mod", {50'd0, core_mod[0], core_mod[1]}, {50'd0, 7'h7F, 7'h7F});
      exp_q0.delete();
      exp_q1.delete();
      tick();
      rst = 1'b0;
      repeat (6) tick();
      check("post_rst_we", {62'd0, prog_we}, 64'd0);
      check("post_rst_wait", {62'd0, io_wait}, 64'd0);
      check("post_rst_done", {32'd0, done_cnt[0]}, 64'd4);
      check("post_rst_done16", {32'd0, done_cnt[1]}, 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
